key_schedule_ctrl_128: RTL and testbench

Sequencer that turns one 128-bit AES cipher key into the full AES-128 key schedule, 11 round keys for rounds 0..10. It time-shares a single external round-expansion stage, issuing ten expansion requests per key with the correct Rcon. It sits between the cipher-key FIFO and the round-key FIFO that feeds the cipher datapath. All streaming ports use the codebase FIFO handshake: `*_rd` against `*_empty`, `*_wr` against `*_full`.

---
 rtl/key_schedule_ctrl_128.sv | 87 ++++++++
 tb/tb_key_schedule_ctrl_128.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_schedule_ctrl_128.sv
// AES-128 key schedule sequencer: reads one cipher key, drives an external
// round-expansion stage ten times and streams round keys 0..10 out.
module key_schedule_ctrl_128 (
  input  logic         clock,
  input  logic         reset,
  input  logic [127:0] in_key,
  input  logic         in_key_empty,
  output logic         in_key_rd,
  output logic [127:0] stage_in_key,
  output logic [7:0]   stage_rcon,
  output logic         stage_in_wr,
  input  logic         stage_in_full,
  input  logic [127:0] stage_out_key,
  input  logic         stage_out_empty,
  output logic         stage_out_rd,
  output logic [127:0] out_key,
  output logic [3:0]   out_round,
  output logic         out_key_wr,
  input  logic         out_key_full,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EMIT  = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  logic [1:0]   state;
  logic [127:0] key_reg;
  logic [3:0]   round;
  logic [7:0]   rcon;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  // Handshakes are qualified by reset so every strobe reads 0 while it is held.
  always_comb begin
    in_key_rd    = reset && (state == IDLE)  && !in_key_empty;
    out_key_wr   = reset && (state == EMIT)  && !out_key_full;
    stage_in_wr  = reset && (state == ISSUE) && !stage_in_full;
    stage_out_rd = reset && (state == WAIT)  && !stage_out_empty;
    done         = out_key_wr && (round == 4'd10);
    busy         = (state != IDLE);
    out_key      = key_reg;
    stage_in_key = key_reg;
    out_round    = round;
    stage_rcon   = rcon;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      key_reg <= '0;
      round   <= '0;
      rcon    <= 8'h01;
    end else begin
      case (state)
        IDLE: begin
          if (in_key_rd) begin
            key_reg <= in_key;
            round   <= '0;
            rcon    <= 8'h01;
            state   <= EMIT;
          end
        end
        EMIT: begin
          if (out_key_wr) state <= (round == 4'd10) ? IDLE : ISSUE;
        end
        ISSUE: begin
          if (stage_in_wr) state <= WAIT;
        end
        WAIT: begin
          if (stage_out_rd) begin
            key_reg <= stage_out_key;
            round   <= round + 4'd1;
            rcon    <= xtime(rcon);
            state   <= EMIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule_ctrl_128.sv
// Scoreboard bench for key_schedule_ctrl_128 with a behavioural expansion stage
// and FIFO models; FIPS-197 A.1 round keys serve as the directed reference.
module tb_key_schedule_ctrl_128;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] in_key = '0;
  logic         in_key_empty = 1'b1;
  logic         in_key_rd;
  logic [127:0] stage_in_key;
  logic [7:0]   stage_rcon;
  logic         stage_in_wr;
  logic         stage_in_full = 1'b0;
  logic [127:0] stage_out_key = '0;
  logic         stage_out_empty = 1'b1;
  logic         stage_out_rd;
  logic [127:0] out_key;
  logic [3:0]   out_round;
  logic         out_key_wr;
  logic         out_key_full = 1'b0;
  logic         busy;
  logic         done;

  key_schedule_ctrl_128 dut (
    .clock(clock), .reset(reset),
    .in_key(in_key), .in_key_empty(in_key_empty), .in_key_rd(in_key_rd),
    .stage_in_key(stage_in_key), .stage_rcon(stage_rcon),
    .stage_in_wr(stage_in_wr), .stage_in_full(stage_in_full),
    .stage_out_key(stage_out_key), .stage_out_empty(stage_out_empty),
    .stage_out_rd(stage_out_rd),
    .out_key(out_key), .out_round(out_round), .out_key_wr(out_key_wr),
    .out_key_full(out_key_full), .busy(busy), .done(done)
  );

  initial forever #5 clock = ~clock;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   round;
    int           rel;
  } sb_t;

  sb_t          sbq[$];
  logic [127:0] kq[$];
  int           checks = 0;
  int           errors = 0;

  // FIPS-197 A.1 round keys, written in spec byte order (byte 0 leftmost)
  logic [127:0] fips_be [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  logic [7:0] rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  function automatic logic [127:0] brev(input logic [127:0] x);
    logic [127:0] y;
    for (int unsigned i = 0; i < 16; i++) y[i*8 +: 8] = x[(15-i)*8 +: 8];
    return y;
  endfunction

  // Stage reference: true AES expansion for the FIPS chain, a simple mix otherwise
  function automatic logic [127:0] stage_fn(input logic [127:0] k, input logic [7:0] rc);
    for (int unsigned i = 0; i < 10; i++)
      if (k == brev(fips_be[i]) && rc == rcon_tab[i]) return brev(fips_be[i+1]);
    return {k[119:0], k[127:120]} ^ {120'd0, rc};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_key(input logic [127:0] k, input bit timed, input bit stall);
    logic [127:0] cur;
    sb_t e;
    cur = k;
    kq.push_back(k);
    for (int unsigned r = 0; r <= 10; r++) begin
      e.key   = cur;
      e.round = 4'(r);
      e.rel   = timed ? int'(1 + 3*r + ((stall && r >= 3) ? 5 : 0)) : -1;
      sbq.push_back(e);
      if (r < 10) cur = stage_fn(cur, rcon_tab[r]);
    end
  endtask

  // environment mode controls and stage model state
  int unsigned  cyc = 0;
  int unsigned  rd_cyc = 0;
  int unsigned  iss_idx = 0;
  int unsigned  n_wr = 0;
  int unsigned  n_rd = 0;
  int unsigned  pend_lat = 0;
  int           gap_rds = 0;
  int unsigned  lat_mode = 0;
  bit           full_burst = 0;
  bit           stall_mode = 0;
  bit           force_res = 0;
  bit           rst_arm = 0;
  bit           rst_trig = 0;
  bit           pend = 0;
  bit           res_valid = 0;
  logic [127:0] pend_key = '0;
  logic [127:0] res_key = '0;
  logic [127:0] ch_key = '0;
  bit           saw_rd, saw_or;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin : env
    forever begin
      @(negedge clock);
      saw_rd = in_key_rd;
      saw_or = stage_out_rd;
      if (force_res && !pend && !res_valid)
        chk("no_pop_outside_wait", 128'(stage_out_rd), 128'(0));
      if (in_key_rd) begin
        chk("busy_at_rd", 128'(busy), 128'(0));
        if (gap_rds == 1) chk("rd_gap", 128'(cyc - rd_cyc), 128'(32));
        if (gap_rds > 0) gap_rds--;
        rd_cyc  = cyc;
        ch_key  = in_key;
        iss_idx = 0;
        n_wr    = 0;
        n_rd    = 0;
      end
      if (stage_in_wr) begin
        chk("one_outstanding", 128'(pend | res_valid), 128'(0));
        if (iss_idx < 10) begin
          chk("stage_rcon", 128'(stage_rcon), 128'(rcon_tab[iss_idx]));
          chk("stage_in_key", stage_in_key, ch_key);
          ch_key = stage_fn(ch_key, rcon_tab[iss_idx]);
        end else begin
          checks++; errors++;
          $display("FAIL extra_issue: issue %0d expected at most 10", iss_idx + 1);
        end
        if (rst_arm && iss_idx == 5) rst_trig = 1;
        iss_idx++;
        n_wr++;
        pend     = 1;
        pend_key = stage_fn(stage_in_key, stage_rcon);
        pend_lat = (lat_mode == 1) ? $urandom_range(0, 7) : (lat_mode == 2) ? 4 : 0;
      end
      if (stage_out_rd) begin
        chk("pop_has_result", 128'(res_valid), 128'(1));
        n_rd++;
      end
      @(posedge clock);
      #1;
      if (saw_rd && kq.size() > 0) void'(kq.pop_front());
      if (saw_or) res_valid = 0;
      if (pend) begin
        if (pend_lat == 0) begin
          res_valid = 1;
          res_key   = pend_key;
          pend      = 0;
        end else pend_lat--;
      end
      in_key_empty    = (kq.size() == 0);
      in_key          = (kq.size() > 0) ? kq[0] : '0;
      stage_out_empty = !(res_valid || (force_res && !pend));
      stage_out_key   = res_valid ? res_key : 128'hdeadbeef_0badf00d_deadbeef_0badf00d;
      stage_in_full   = full_burst ? ($urandom_range(0, 2) == 0) : 1'b0;
      out_key_full    = stall_mode && (cyc - rd_cyc >= 10) && (cyc - rd_cyc <= 14);
    end
  end

  initial begin : monitor
    sb_t e;
    forever begin
      @(negedge clock);
      if (done) chk("done_with_wr", 128'(out_key_wr), 128'(1));
      if (out_key_full && busy) begin
        chk("stall_no_wr", 128'(out_key_wr), 128'(0));
        chk("stall_round", 128'(out_round), 128'(3));
        chk("stall_key", out_key, brev(fips_be[3]));
      end
      if (out_key_wr) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: round %0d key %h, nothing expected", out_round, out_key);
        end else begin
          e = sbq.pop_front();
          chk("out_key", out_key, e.key);
          chk("out_round", 128'(out_round), 128'(e.round));
          chk("done", 128'(done), 128'(e.round == 4'd10));
          chk("busy_at_wr", 128'(busy), 128'(1));
          if (e.rel >= 0) chk("write_cycle", 128'(cyc - rd_cyc), 128'(e.rel));
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (sbq.size() == 0 && kq.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_timeout: %0d writes outstanding, expected 0", name, sbq.size());
      sbq.delete();
      kq.delete();
    end
  endtask

  task automatic check_counts(input string name);
    chk({name, "_issues"}, 128'(n_wr), 128'(10));
    chk({name, "_pops"}, 128'(n_rd), 128'(10));
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_in_key_rd"}, 128'(in_key_rd), 128'(0));
    chk({name, "_stage_in_wr"}, 128'(stage_in_wr), 128'(0));
    chk({name, "_stage_out_rd"}, 128'(stage_out_rd), 128'(0));
    chk({name, "_out_key_wr"}, 128'(out_key_wr), 128'(0));
    chk({name, "_busy"}, 128'(busy), 128'(0));
    chk({name, "_done"}, 128'(done), 128'(0));
    chk({name, "_out_key"}, out_key, 128'(0));
    chk({name, "_stage_in_key"}, stage_in_key, 128'(0));
    chk({name, "_out_round"}, 128'(out_round), 128'(0));
    chk({name, "_stage_rcon"}, 128'(stage_rcon), 128'(8'h01));
  endtask

  initial begin : main
    logic [127:0] fk;
    bit got;
    fk = brev(fips_be[0]);

    // key waiting in the FIFO while reset is held must not be popped
    push_key(fk, 1, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_reset_outputs("reset");
    @(posedge clock);
    #2 reset = 1'b1;
    wait_idle("fips");
    check_counts("fips");

    stall_mode = 1;
    push_key(fk, 1, 1);
    wait_idle("stall");
    stall_mode = 0;

    lat_mode = 1;
    full_burst = 1;
    push_key(128'h00112233_44556677_8899aabb_ccddeeff, 0, 0);
    wait_idle("rand_a");
    check_counts("rand_a");
    push_key(fk, 0, 0);
    wait_idle("rand_b");
    check_counts("rand_b");
    lat_mode = 0;
    full_burst = 0;

    force_res = 1;
    push_key(fk, 1, 0);
    wait_idle("forced");
    force_res = 0;

    gap_rds = 2;
    push_key(fk, 1, 0);
    push_key(128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, 1, 0);
    wait_idle("b2b");
    check_counts("b2b");

    // abandon a schedule in WAIT at round 5
    lat_mode = 2;
    rst_arm = 1;
    push_key(128'hcafef00d_12345678_9abcdef0_0fedcba9, 0, 0);
    got = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (rst_trig) begin
        got = 1;
        break;
      end
    end
    chk("reach_round5_wait", 128'(got), 128'(1));
    @(posedge clock);
    #3 reset = 1'b0;
    #1 check_reset_outputs("async_reset");
    pend = 0;
    res_valid = 0;
    rst_arm = 0;
    rst_trig = 0;
    lat_mode = 0;
    sbq.delete();
    kq.delete();
    repeat (2) @(posedge clock);
    #2 reset = 1'b1;
    push_key(fk, 1, 0);
    wait_idle("after_reset");
    check_counts("after_reset");

    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
